ram_1p_secure_scrub: RTL and testbench

Parametrised single-port, constant-activity data RAM for the secure core's instruction/data bus. It generalises the one-hot banked RAM in word width, register-per-block and block count. Reads always evaluate every register through a one-hot AND-OR network, then a registered binary mux tree across blocks. New in this block: a zeroisation (scrub) state machine that clears the whole array on request or after reset, and response-data gating so `rdata_o` is zero unless a read response is valid.

---
 rtl/ram_1p_secure_scrub.sv | 179 +++++++++++++++++
 tb/tb_ram_1p_secure_scrub.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_1p_secure_scrub.sv
// Single-port constant-activity RAM with one-hot AND-OR read network,
// registered block mux, and a zeroisation (scrub) state machine.
module ram_1p_secure_scrub #(
  parameter int DataWidth    = 32,
  parameter int RegIdxW      = 3,
  parameter int BlockIdxW    = 4,
  parameter bit ScrubOnReset = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [DataWidth/8-1:0] be_i,
  input  logic [31:0]            addr_i,
  input  logic [DataWidth-1:0]   wdata_i,
  output logic                   gnt_o,
  output logic                   rvalid_o,
  output logic [DataWidth-1:0]   rdata_o,
  input  logic                   scrub_req_i,
  output logic                   scrub_busy_o,
  output logic                   scrub_done_o
);

  localparam int NumBytes  = DataWidth / 8;
  localparam int ByteOffW  = $clog2(NumBytes);
  localparam int NumRegs   = 2 ** RegIdxW;
  localparam int NumBlocks = 2 ** BlockIdxW;
  localparam int AddrW     = ByteOffW + RegIdxW + BlockIdxW;

  typedef enum logic [1:0] {IDLE, DRAIN, SCRUB, DONE} state_e;

  state_e                 state, state_nxt;
  logic [BlockIdxW-1:0]   cnt, cnt_nxt;
  logic                   scrub_en;
  logic                   done;

  logic [RegIdxW-1:0]     reg_idx;
  logic [BlockIdxW-1:0]   blk_idx;
  logic                   unused_addr;

  logic [NumRegs-1:0]     onehot_p0;
  logic [BlockIdxW-1:0]   blk_p0;
  logic                   we_p0;
  logic [NumBytes-1:0]    be_p0;
  logic [DataWidth-1:0]   wdata_p0;

  logic [DataWidth-1:0]   mem   [NumBlocks][NumRegs];
  logic [DataWidth-1:0]   rd_d  [NumBlocks];
  logic [DataWidth-1:0]   rd_p1 [NumBlocks];
  logic [BlockIdxW-1:0]   blk_p1;
  logic                   rvalid_p1;
  logic                   wresp_p1;

  assign reg_idx     = addr_i[ByteOffW +: RegIdxW];
  assign blk_idx     = addr_i[ByteOffW + RegIdxW +: BlockIdxW];
  assign unused_addr = ^{addr_i[31:AddrW], addr_i[ByteOffW-1:0]};

  assign gnt_o        = req_i & (state == IDLE) & ~scrub_req_i;
  assign scrub_busy_o = (state != IDLE);
  assign scrub_done_o = done;
  assign scrub_en     = (state == SCRUB);

  // Scrub FSM state and block/drain counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ScrubOnReset ? SCRUB : IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Scrub FSM next state; counter doubles as the two-cycle drain timer
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (scrub_req_i) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end
      end
      DRAIN: begin
        if (cnt == BlockIdxW'(1)) begin
          state_nxt = SCRUB;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + BlockIdxW'(1);
        end
      end
      SCRUB: begin
        if (cnt == BlockIdxW'(NumBlocks - 1)) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + BlockIdxW'(1);
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: request capture; an ungranted cycle loads zeros
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      onehot_p0 <= '0;
      blk_p0    <= '0;
      we_p0     <= 1'b0;
      be_p0     <= '0;
      wdata_p0  <= '0;
    end else if (gnt_o) begin
      onehot_p0 <= NumRegs'(1) << reg_idx;
      blk_p0    <= blk_idx;
      we_p0     <= we_i;
      be_p0     <= be_i;
      wdata_p0  <= wdata_i;
    end else begin
      onehot_p0 <= '0;
      blk_p0    <= '0;
      we_p0     <= 1'b0;
      be_p0     <= '0;
      wdata_p0  <= '0;
    end
  end

  // Array update: scrub clears a whole block, otherwise byte-enabled write
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NumBlocks; b++) begin
      for (int r = 0; r < NumRegs; r++) begin
        if (scrub_en && (cnt == BlockIdxW'(b))) begin
          mem[b][r] <= '0;
        end else if (we_p0 && (blk_p0 == BlockIdxW'(b)) && onehot_p0[r]) begin
          for (int k = 0; k < NumBytes; k++) begin
            if (be_p0[k]) mem[b][r][8*k +: 8] <= wdata_p0[8*k +: 8];
          end
        end
      end
    end
  end

  // One-hot AND-OR over every register of every block, every cycle
  always_comb begin
    for (int b = 0; b < NumBlocks; b++) begin
      rd_d[b] = '0;
      for (int r = 0; r < NumRegs; r++) begin
        rd_d[b] = rd_d[b] | (mem[b][r] & {DataWidth{onehot_p0[r] & ~we_p0}});
      end
    end
  end

  // Stage p1: per-block read registers (data path, not reset)
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NumBlocks; b++) rd_p1[b] <= rd_d[b];
  end

  // Stage p1: response control; reset drops any in-flight response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      blk_p1    <= '0;
      rvalid_p1 <= 1'b0;
      wresp_p1  <= 1'b0;
    end else begin
      blk_p1    <= blk_p0;
      rvalid_p1 <= |onehot_p0;
      wresp_p1  <= we_p0;
    end
  end

  assign rvalid_o = rvalid_p1;
  assign rdata_o  = rd_p1[blk_p1] & {DataWidth{rvalid_p1 & ~wresp_p1}};

endmodule

// File: tb/tb_ram_1p_secure_scrub.sv
// Self-checking bench: two instances (ScrubOnReset 0 and 1) share one bus;
// a per-instance reference model tracks memory, scrub timeline and responses.
module tb_ram_1p_secure_scrub;

  localparam int NB = 16;

  logic        clk = 1'b0;
  logic        rst1, rst2, req, we, scrub1, scrub2;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        gnt1, rvalid1, busy1, done1;
  logic        gnt2, rvalid2, busy2, done2;
  logic [31:0] rdata1, rdata2;

  always #5 clk = ~clk;

  ram_1p_secure_scrub #(.DataWidth(32), .RegIdxW(3), .BlockIdxW(4), .ScrubOnReset(1'b0)) u_dut1 (
    .clk_i(clk), .rst_i(rst1), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
    .wdata_i(wdata), .gnt_o(gnt1), .rvalid_o(rvalid1), .rdata_o(rdata1),
    .scrub_req_i(scrub1), .scrub_busy_o(busy1), .scrub_done_o(done1));

  ram_1p_secure_scrub #(.DataWidth(32), .RegIdxW(3), .BlockIdxW(4), .ScrubOnReset(1'b1)) u_dut2 (
    .clk_i(clk), .rst_i(rst2), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
    .wdata_i(wdata), .gnt_o(gnt2), .rvalid_o(rvalid2), .rdata_o(rdata2),
    .scrub_req_i(scrub2), .scrub_busy_o(busy2), .scrub_done_o(done2));

  // Reference model. t_m: -1 = idle, 1..2 drain, 3..3+NB-1 scrub block t-3, 3+NB done.
  logic [31:0] mem_m [2][128];
  int          t_m [2];
  bit          pv1 [2], pv2 [2];
  logic [31:0] pd1 [2], pd2 [2];

  int          checks = 0, errors = 0, cyc_n = 0;
  logic [31:0] last_rdata1;
  logic        last_rvalid1, last_gnt1, last_done1, last_done2, last_busy2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc_n, obs, exp);
    end
  endtask

  task automatic cyc(input bit rq, input bit w, input logic [3:0] b, input logic [31:0] a,
                     input logic [31:0] d, input bit s1, input bit s2);
    bit         eg [2];
    bit         rs [2];
    bit         sq [2];
    logic [6:0] idx;
    req = rq; we = w; be = b; addr = a; wdata = d; scrub1 = s1; scrub2 = s2;
    rs[0] = rst1; rs[1] = rst2; sq[0] = s1; sq[1] = s2;
    for (int i = 0; i < 2; i++) eg[i] = rq && (t_m[i] < 0) && !sq[i] && !rs[i];
    @(negedge clk);
    chk("gnt1",    gnt1,    eg[0]);
    chk("rvalid1", rvalid1, pv2[0]);
    chk("rdata1",  rdata1,  pv2[0] ? pd2[0] : 32'h0);
    chk("busy1",   busy1,   t_m[0] >= 1);
    chk("done1",   done1,   (t_m[0] == 3 + NB) && !rs[0]);
    chk("gnt2",    gnt2,    eg[1]);
    chk("rvalid2", rvalid2, pv2[1]);
    chk("rdata2",  rdata2,  pv2[1] ? pd2[1] : 32'h0);
    chk("busy2",   busy2,   t_m[1] >= 1);
    chk("done2",   done2,   (t_m[1] == 3 + NB) && !rs[1]);
    last_rdata1 = rdata1; last_rvalid1 = rvalid1; last_gnt1 = gnt1;
    last_done1 = done1; last_done2 = done2; last_busy2 = busy2;
    idx = a[8:2];
    for (int i = 0; i < 2; i++) begin
      if (rs[i]) begin
        pv1[i] = 1'b0; pv2[i] = 1'b0;
      end else begin
        pv2[i] = pv1[i]; pd2[i] = pd1[i];
        pv1[i] = eg[i];  pd1[i] = 32'h0;
        if (eg[i]) begin
          if (w) begin
            for (int k = 0; k < 4; k++)
              if (b[k]) mem_m[i][idx][8*k +: 8] = d[8*k +: 8];
          end else begin
            pd1[i] = mem_m[i][idx];
          end
        end
        if (t_m[i] < 0) begin
          if (sq[i]) t_m[i] = 1;
        end else if (t_m[i] == 3 + NB) begin
          t_m[i] = -1;
        end else begin
          if (t_m[i] >= 3)
            for (int r = 0; r < 8; r++) mem_m[i][(t_m[i] - 3) * 8 + r] = 32'h0;
          t_m[i]++;
        end
      end
    end
    @(posedge clk); #1;
    cyc_n++;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic fill_addr();
    for (int j = 0; j < 128; j++) cyc(1'b1, 1'b1, 4'hF, j * 4, j * 4, 1'b0, 1'b0);
    idle(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [31:0] ra;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 128; j++) mem_m[i][j] = 32'h0;
      pv1[i] = 1'b0; pv2[i] = 1'b0; pd1[i] = 32'h0; pd2[i] = 32'h0;
    end
    t_m[0] = -1; t_m[1] = 3;
    rst1 = 1'b1; rst2 = 1'b1;
    req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
    scrub1 = 1'b0; scrub2 = 1'b0;
    @(posedge clk); #1;

    // Reset held: all responses quiet, instance 2 parked in SCRUB
    idle(3);
    rst1 = 1'b0; rst2 = 1'b0;
    // Idle bus while instance 2 runs its power-on scrub
    idle(20);

    fill_addr();

    // Full write then read, write response returns zero data
    cyc(1'b1, 1'b1, 4'hF, 32'h004, 32'hDEADBEEF, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 4'h0, 32'h004, 32'h0, 1'b0, 1'b0);
    idle(1);
    chk("wr_resp_valid", last_rvalid1, 1'b1);
    chk("wr_resp_data",  last_rdata1,  32'h0);
    idle(1);
    chk("rd_deadbeef",   last_rdata1,  32'hDEADBEEF);

    // Partial byte-enable write, neighbour untouched
    cyc(1'b1, 1'b1, 4'hF, 32'h1FC, 32'h11223344, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 4'h5, 32'h1FC, 32'hAABBCCDD, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 4'h0, 32'h1FC, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 4'h0, 32'h1F8, 32'h0, 1'b0, 1'b0);
    idle(1);
    chk("rd_be_merge", last_rdata1, 32'h11BB33DD);
    idle(1);
    chk("rd_neighbour", last_rdata1, 32'h000001F8);

    // Read immediately after write to the same word
    cyc(1'b1, 1'b1, 4'hF, 32'h040, 32'h0000CAFE, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 4'h0, 32'h040, 32'h0, 1'b0, 1'b0);
    idle(1);
    idle(1);
    chk("rd_after_wr", last_rdata1, 32'h0000CAFE);

    // Randomised traffic, upper address bits random
    for (int j = 0; j < 300; j++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom),
          $urandom, $urandom, 1'b0, 1'b0);
    idle(2);

    // Scrub request with a read in flight, bus kept busy
    fill_addr();
    cyc(1'b1, 1'b0, 4'h0, 32'h080, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 4'h0, 32'h084, 32'h0, 1'b1, 1'b0);
    chk("scrub_gnt_S", last_gnt1, 1'b0);
    for (int c = 1; c <= 19; c++) begin
      ra = $urandom;
      cyc(1'b1, $urandom_range(0, 1) == 1, 4'hF, ra, $urandom, 1'b0, 1'b0);
      if (c == 1) chk("inflight_rd", last_rdata1, 32'h00000080);
      chk("scrub_gnt", last_gnt1, 1'b0);
      chk("scrub_done_pulse", last_done1, c == 19);
    end
    for (int j = 0; j < 128; j++) cyc(1'b1, 1'b0, 4'h0, j * 4, 32'h0, 1'b0, 1'b0);
    idle(2);

    // Instance 2: reset during 5th SCRUB cycle, scrub restarts from block 0
    fill_addr();
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    n = 0;
    while (t_m[1] != 7 && n < 20) begin
      idle(1);
      n++;
    end
    chk("reach_scrub5", n, 6);
    rst2 = 1'b1; t_m[1] = 3;
    idle(2);
    rst2 = 1'b0;
    idle(1);
    chk("rst_release_busy", last_busy2, 1'b1);
    n = 0;
    while (!last_done2 && n < 40) begin
      idle(1);
      n++;
    end
    chk("rst_done_delay", n, 16);
    idle(2);
    for (int j = 0; j < 128; j++) cyc(1'b1, 1'b0, 4'h0, j * 4, 32'h0, 1'b0, 1'b0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
